multirate_v2_mac_pipe: RTL and testbench
========================================

MULTIRATE_V2_MAC_PIPE -- requirements
Module: multirate_v2_mac_pipe

Interface
REQ-001 SHALL have parameter DIN0_WIDTH, default 16, width of signed sample operand din0.
REQ-002 SHALL have parameter DIN1_WIDTH, default 11, width of coefficient operand din1.
REQ-003 SHALL have parameter DIN1_SIGNED, default 0, where 0 means din1 is unsigned (zero-extended) and 1 means din1 is two's complement.
REQ-004 SHALL have parameter NUM_STAGE, default 2, number of product pipeline registers (legal 1..4).
REQ-005 SHALL have parameter ACC_WIDTH, default 40, accumulator width (≥ DIN0_WIDTH+DIN1_WIDTH+1).
REQ-006 SHALL have parameter SHIFT, default 10, right shift applied to the accumulator before output (0..ACC_WIDTH-1).
REQ-007 SHALL have parameter DOUT_WIDTH, default 16, signed result width.
REQ-008 SHALL have port ap_clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-009 SHALL have port ap_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-010 SHALL have ports in_valid (input, 1), in_ready (output, 1), din0 (input, DIN0_WIDTH), din1 (input, DIN1_WIDTH), in_first (input, 1, first tap of frame) and in_last (input, 1, last tap of frame).
REQ-011 SHALL have ports out_valid (output, 1), out_ready (input, 1), dout (output, DOUT_WIDTH, signed frame result), out_sat (output, 1, dout was clipped) and err (output, 1, one-cycle protocol-error pulse).

Function
REQ-012 SHALL accept a beat when in_valid and in_ready are both 1 in the same cycle.
REQ-013 SHALL drive in_ready = NOT(out_valid AND NOT out_ready); when in_ready is 0, the product pipeline, accumulator and FSM SHALL all hold.
REQ-014 SHALL form the product as the full-precision signed product din0 × din1, with din1 extended per DIN1_SIGNED and the result width DIN0_WIDTH+DIN1_WIDTH+1.
REQ-015 SHALL carry each product through exactly NUM_STAGE registers, each tagged with valid, first and last bits.
REQ-016 SHALL implement FSM states IDLE and ACCUM, evaluated on products leaving the pipeline.
REQ-017 In IDLE, a product with first=1 SHALL set acc = sign-extended product and go to ACCUM, or stay in IDLE if last=1.
REQ-018 In IDLE, a product with first=0 SHALL be discarded, SHALL pulse err for 1 cycle, and SHALL leave the FSM in IDLE.
REQ-019 In ACCUM, a product with first=0 SHALL set acc = acc + product, wrapping modulo 2^ACC_WIDTH.
REQ-020 In ACCUM, a product with first=1 SHALL discard the partial sum, pulse err, reload acc = product, and stay in ACCUM.
REQ-021 A product with last=1 that completes a frame, including a first=last single-tap frame, SHALL load the output register and return the FSM to IDLE.
REQ-022 SHALL compute the output as r = acc + 2^(SHIFT-1) when SHIFT>0 (else r = acc), followed by an arithmetic right shift by SHIFT.
REQ-023 SHALL saturate r to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1], setting out_sat=1 when clipped and out_sat=0 otherwise.
REQ-024 SHALL assert out_valid NUM_STAGE+1 cycles after the accepting edge of the last beat when there is no stall.
REQ-025 SHALL keep out_valid, dout and out_sat stable until the out_valid AND out_ready handshake completes.
REQ-026 SHALL sustain throughput of one beat per cycle when out_ready=1, including back-to-back frames.
REQ-027 SHALL clear out_valid on handshake unless a new result loads in the same cycle, in which case out_valid stays 1 with the new data.

Reset
REQ-028 While ap_rst_n=0, SHALL force out_valid=0, dout=0, out_sat=0, err=0, acc=0, FSM=IDLE and all pipeline valid bits to 0.
REQ-029 While ap_rst_n=0, in_ready SHALL read 1; a frame interrupted by reset SHALL be lost with no partial output after release.
REQ-030 Reset assertion SHALL take effect without a clock edge; release SHALL be synchronous to ap_clk.

Verification
REQ-031 With default parameters, a single beat din0=-3, din1=2047, first=last=1 SHALL give dout=-6, out_sat=0, with out_valid 3 cycles after accept.
REQ-032 A 4-beat frame of din0=1000, din1=1024 SHALL give acc=4096000 and dout=4000, out_sat=0.
REQ-033 A 64-beat frame of din0=32767, din1=2047 SHALL give dout=32767 and out_sat=1; the same frame with din0=-32768 SHALL give dout=-32768 and out_sat=1.
REQ-034 Holding out_ready=0 for 5 cycles during streaming SHALL hold in_ready=0, keep dout constant and lose no beats; the next frames SHALL match the golden model.
REQ-035 A beat with first=0 in IDLE SHALL produce an err pulse and no output, and first=1 mid-frame SHALL produce err with the result covering only the new frame.
REQ-036 With ap_rst_n pulsed low mid-frame, all outputs SHALL read 0 immediately; with DIN1_SIGNED=1, din1=11'h7FF and din0=5 with SHIFT=0 SHALL give dout=-5.

Source files
------------

// File: rtl/multirate_v2_mac_pipe.sv
// -----------------------------------------------------------------------------
// multirate_v2_mac_pipe
//
// Frame-based multiply-accumulate. Each accepted beat forms the full-precision
// signed product din0 * din1 and carries it, with its first/last frame tags,
// through NUM_STAGE registers. A two-state FSM at the pipeline exit builds the
// frame sum in a wrapping ACC_WIDTH accumulator. When a frame's last tap
// lands, the sum is rounded (add half an LSB, arithmetic shift right by
// SHIFT), saturated to DOUT_WIDTH and parked in the output register until
// the consumer takes it.
//
// Ports
//   ap_clk     : clock, rising edge
//   ap_rst_n   : asynchronous active-low reset
//   in_valid   : input beat valid
//   in_ready   : input beat may be accepted (low only while a result is stuck)
//   din0       : signed sample operand
//   din1       : coefficient operand (signed or unsigned per DIN1_SIGNED)
//   in_first   : beat is the first tap of a frame
//   in_last    : beat is the last tap of a frame
//   out_valid  : frame result available
//   out_ready  : consumer accepts the result
//   dout       : signed, rounded, saturated frame result
//   out_sat    : dout was clipped
//   err        : one-cycle pulse on a framing error (orphan tap or early first)
// -----------------------------------------------------------------------------
module multirate_v2_mac_pipe #(
    parameter int DIN0_WIDTH  = 16,
    parameter int DIN1_WIDTH  = 11,
    parameter int DIN1_SIGNED = 0,
    parameter int NUM_STAGE   = 2,
    parameter int ACC_WIDTH   = 40,
    parameter int SHIFT       = 10,
    parameter int DOUT_WIDTH  = 16
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DIN0_WIDTH-1:0] din0,
    input  logic        [DIN1_WIDTH-1:0] din1,
    input  logic                         in_first,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         out_sat,
    output logic                         err
);

    localparam int PW = DIN0_WIDTH + DIN1_WIDTH + 1;

    // Half-LSB rounding constant; collapses to zero when SHIFT is zero.
    localparam logic [ACC_WIDTH:0] RND = ((ACC_WIDTH+1)'(1) << SHIFT) >> 1;

    // Saturation limits expressed at the shifted-accumulator width.
    localparam logic signed [ACC_WIDTH:0] SAT_MAX =
        {{(ACC_WIDTH+2-DOUT_WIDTH){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_MIN =
        {{(ACC_WIDTH+2-DOUT_WIDTH){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};
    localparam logic signed [DOUT_WIDTH-1:0] DOUT_MAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic signed [DOUT_WIDTH-1:0] DOUT_MIN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

    typedef struct packed {
        logic                 vld;
        logic                 first;
        logic                 last;
        logic signed [PW-1:0] prod;
    } stage_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Flow control: the whole datapath advances only when the output
    // register is empty or being drained this cycle.
    // ------------------------------------------------------------------
    logic out_valid_q;
    logic en;

    assign in_ready = ~(out_valid_q & ~out_ready);
    assign en       = in_ready;

    // ------------------------------------------------------------------
    // Product
    // ------------------------------------------------------------------
    logic signed [DIN1_WIDTH:0] din1_x;
    logic signed [PW-1:0]       prod_d;
    stage_t                     stg_in_d;

    assign din1_x = (DIN1_SIGNED != 0) ? {din1[DIN1_WIDTH-1], din1} : {1'b0, din1};
    assign prod_d = PW'(din0) * PW'(din1_x);

    always_comb begin
        stg_in_d       = '0;
        stg_in_d.vld   = in_valid;
        stg_in_d.first = in_first;
        stg_in_d.last  = in_last;
        stg_in_d.prod  = prod_d;
    end

    // ------------------------------------------------------------------
    // Product pipeline, NUM_STAGE tagged registers
    // ------------------------------------------------------------------
    stage_t pipe_q [NUM_STAGE];
    stage_t ex;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < NUM_STAGE; i++) pipe_q[i] <= '0;
        end else if (en) begin
            pipe_q[0] <= stg_in_d;
            for (int i = 1; i < NUM_STAGE; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign ex = pipe_q[NUM_STAGE-1];

    // ------------------------------------------------------------------
    // Accumulate FSM on products leaving the pipeline
    // ------------------------------------------------------------------
    state_t                      state_q;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic                        fin_q;   // acc_q holds a finished frame sum
    logic                        err_q;

    assign prod_ext = ACC_WIDTH'($signed(ex.prod));

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            fin_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // err is a pulse; a stalled exit product is flagged only once,
            // when it is finally consumed.
            err_q <= 1'b0;
            if (en) begin
                fin_q <= 1'b0;
                if (ex.vld) begin
                    case (state_q)
                        IDLE: begin
                            if (ex.first) begin
                                acc_q <= prod_ext;
                                if (ex.last) fin_q   <= 1'b1;
                                else         state_q <= ACCUM;
                            end else begin
                                // Orphan tap with no open frame: drop it.
                                err_q <= 1'b1;
                            end
                        end
                        ACCUM: begin
                            if (ex.first) begin
                                // New frame before the old one closed: restart.
                                err_q <= 1'b1;
                                acc_q <= prod_ext;
                            end else begin
                                acc_q <= acc_q + prod_ext;
                            end
                            if (ex.last) begin
                                fin_q   <= 1'b1;
                                state_q <= IDLE;
                            end
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Round, shift, saturate. One bit of headroom keeps the rounding add
    // exact even at the accumulator's positive limit.
    // ------------------------------------------------------------------
    logic signed [ACC_WIDTH:0]    rnd_d;
    logic signed [ACC_WIDTH:0]    shr_d;
    logic                         sat_hi_d;
    logic                         sat_lo_d;
    logic signed [DOUT_WIDTH-1:0] dout_d;

    assign rnd_d    = $signed({acc_q[ACC_WIDTH-1], acc_q}) + $signed(RND);
    assign shr_d    = rnd_d >>> SHIFT;
    assign sat_hi_d = (shr_d > SAT_MAX);
    assign sat_lo_d = (shr_d < SAT_MIN);
    assign dout_d   = sat_hi_d ? DOUT_MAX :
                      sat_lo_d ? DOUT_MIN : shr_d[DOUT_WIDTH-1:0];

    // ------------------------------------------------------------------
    // Output register. A finished sum loads whenever the datapath
    // advances, which also covers load-on-handshake back-to-back.
    // ------------------------------------------------------------------
    logic signed [DOUT_WIDTH-1:0] dout_q;
    logic                         sat_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            sat_q       <= 1'b0;
        end else if (fin_q && en) begin
            out_valid_q <= 1'b1;
            dout_q      <= dout_d;
            sat_q       <= sat_hi_d | sat_lo_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign out_sat   = sat_q;
    assign err       = err_q;

endmodule

// File: tb/tb_multirate_v2_mac_pipe.sv
module tb_multirate_v2_mac_pipe;

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    always #5 ap_clk = ~ap_clk;

    logic               in_valid = 1'b0;
    logic               in_first = 1'b0;
    logic               in_last  = 1'b0;
    logic               out_ready = 1'b1;
    logic signed [15:0] din0 = '0;
    logic        [10:0] din1 = '0;

    logic               in_ready, out_valid, out_sat, err;
    logic signed [15:0] dout;
    logic               s_in_ready, s_out_valid, s_out_sat, s_err;
    logic signed [15:0] s_dout;

    multirate_v2_mac_pipe u_dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .din0(din0), .din1(din1), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .out_sat(out_sat), .err(err)
    );

    multirate_v2_mac_pipe #(.DIN1_SIGNED(1), .SHIFT(0)) u_sgn (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .din0(din0), .din1(din1), .in_first(in_first), .in_last(in_last),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .dout(s_dout), .out_sat(s_out_sat), .err(s_err)
    );

    int chk = 0;
    int errs = 0;

    typedef struct {
        logic signed [63:0] d;
        logic               s;
    } exp_t;
    exp_t sb[$];

    int     m_state = 0;
    longint m_acc = 0;
    int     err_exp = 0;
    int     err_seen = 0;

    logic               prev_stall = 1'b0;
    logic signed [15:0] prev_dout = '0;
    logic               prev_sat = 1'b0;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        chk++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint wrap40(input longint x);
        logic [63:0] v;
        v = x;
        return {{24{v[39]}}, v[39:0]};
    endfunction

    // Golden model of one accepted beat (default parameters).
    task automatic model_beat(input logic f, input logic l);
        longint p, r;
        exp_t   e;
        p = longint'(din0) * longint'({1'b0, din1});
        if (m_state == 0 && !f) begin
            err_exp++;
            return;
        end
        if (m_state == 1 && f) err_exp++;
        if (f) m_acc = wrap40(p);
        else   m_acc = wrap40(m_acc + p);
        if (l) begin
            r = (m_acc + 512) >>> 10;
            if (r > 32767)       begin e.d = 32767;  e.s = 1'b1; end
            else if (r < -32768) begin e.d = -32768; e.s = 1'b1; end
            else                 begin e.d = r;      e.s = 1'b0; end
            sb.push_back(e);
            m_state = 0;
        end else begin
            m_state = 1;
        end
    endtask

    task automatic send(input logic signed [15:0] a, input logic [10:0] b,
                        input logic f, input logic l);
        int   n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        din0 = a; din1 = b; in_first = f; in_last = l; in_valid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge ap_clk);
            ok = in_ready;
            @(posedge ap_clk);
            #1;
            n++;
        end
        check("accept", ok, 1);
        if (ok) model_beat(f, l);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 500) begin
            @(negedge ap_clk);
            n++;
        end
        check("drain", sb.size(), 0);
        repeat (3) @(posedge ap_clk);
        #1;
    endtask

    // Output monitor: scoreboard pops, hold-while-stalled, err pulse count.
    always @(negedge ap_clk) begin
        if (ap_rst_n) begin
            if (err) err_seen++;
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_dout", dout, prev_dout);
                check("hold_sat", out_sat, prev_sat);
            end
            if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                check("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("dout", dout, e.d);
                    check("out_sat", out_sat, e.s);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_dout  = dout;
            prev_sat   = out_sat;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        repeat (2) @(posedge ap_clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_err", err, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;

        // Single-tap frame and latency
        send(-16'sd3, 11'd2047, 1'b1, 1'b1);
        repeat (2) @(negedge ap_clk);
        @(negedge ap_clk);
        check("lat_minus1", out_valid, 0);
        @(negedge ap_clk);
        check("lat_valid", out_valid, 1);
        check("single_dout", dout, -6);
        check("single_sat", out_sat, 0);
        drain();

        // Four-tap frame
        for (int i = 0; i < 4; i++) send(16'sd1000, 11'd1024, i == 0, i == 3);
        drain();

        // Saturating frames, both signs, back-to-back
        for (int i = 0; i < 64; i++) send(16'sd32767, 11'd2047, i == 0, i == 63);
        for (int i = 0; i < 64; i++) send(-16'sd32768, 11'd2047, i == 0, i == 63);
        drain();

        // Streaming with a five-cycle consumer stall
        fork
            begin
                for (int f = 0; f < 8; f++) begin
                    int len;
                    len = $urandom_range(1, 2);
                    for (int j = 0; j < len; j++)
                        send(16'($urandom), 11'($urandom), j == 0, j == len - 1);
                end
            end
            begin
                repeat (6) @(posedge ap_clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge ap_clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Framing errors: orphan tap, then restart mid-frame
        send(16'sd55, 11'd100, 1'b0, 1'b0);
        send(16'sd100, 11'd1024, 1'b1, 1'b0);
        send(16'sd200, 11'd1024, 1'b0, 1'b0);
        send(16'sd7, 11'd1024, 1'b1, 1'b0);
        send(16'sd9, 11'd1024, 1'b0, 1'b1);
        drain();
        check("err_count", err_seen, err_exp);
        check("err_count_min", err_seen, 2);

        // Signed coefficient instance, no shift
        send(16'sd5, 11'h7FF, 1'b1, 1'b1);
        repeat (4) @(negedge ap_clk);
        check("sgn_valid", s_out_valid, 1);
        check("sgn_dout", s_dout, -5);
        check("sgn_sat", s_out_sat, 0);
        drain();

        // Reset mid-frame with a result parked in the output register
        out_ready = 1'b0;
        send(16'sd10, 11'd1024, 1'b1, 1'b1);
        send(16'sd20, 11'd1024, 1'b1, 1'b0);
        send(16'sd30, 11'd1024, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge ap_clk);
            n++;
        end
        check("parked_valid", out_valid, 1);
        #2 ap_rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_dout", dout, 0);
        check("arst_out_sat", out_sat, 0);
        check("arst_err", err, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_s_out_valid", s_out_valid, 0);
        sb.delete();
        m_state = 0;
        m_acc = 0;
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (10) @(posedge ap_clk);
        #1;
        check("no_partial_out", out_valid, 0);
        send(16'sd40, 11'd1024, 1'b1, 1'b1);
        drain();
        check("err_count_final", err_seen, err_exp);
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", chk, errs);
        $finish;
    end

endmodule
